// File: rtl/redmule_pkg.sv
// Shared RedMulE defaults and the X loader job configuration bundle.
package redmule_pkg;

    localparam int ARRAY_WIDTH = 12;
    localparam int DATA_W      = 288;
    localparam int X_BITW      = 16;
    localparam int X_NTILE_W   = 16;
    localparam int X_ROW_W     = $clog2(ARRAY_WIDTH + 1);
    localparam int X_ELEM_W    = $clog2(DATA_W / X_BITW + 1);

    // One X loader job: rows per tile, tile count, valid lanes on the last tile.
    typedef struct packed {
        logic [X_ROW_W-1:0]   rows;
        logic [X_NTILE_W-1:0] tiles;
        logic [X_ELEM_W-1:0]  last_elems;
    } x_loader_cfg_t;

endpackage

// File: rtl/redmule_x_loader_if.sv
// Streamer -> X loader word stream.
// Handshake: a word transfers on every rising clock edge where valid and
// ready are both 1. While valid is 1 and ready is 0 the master keeps data
// stable; ready may depend on state but never on valid.
interface redmule_x_loader_if #(
    parameter int DW = 288
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/redmule_x_lane_mask.sv
// Zeroes element lanes at or above a lane count; a count of 0 keeps all lanes.
module redmule_x_lane_mask #(
    parameter int DW   = 288,
    parameter int BITW = 16,
    parameter int EW   = $clog2(DW / BITW + 1)
) (
    input  logic [EW-1:0] count,
    input  logic [DW-1:0] raw_word,
    output logic [DW-1:0] masked_word
);
    localparam int LANES = DW / BITW;

    // Lane i is kept when count is 0 or i < count; lane 0 sits at the LSBs.
    always_comb begin
        masked_word = raw_word;
        for (int i = 0; i < LANES; i++) begin
            if (count != '0 && i >= int'(count)) begin
                masked_word[i*BITW +: BITW] = '0;
            end
        end
    end
endmodule

// File: rtl/redmule_x_loader.sv
// X operand loader: streams tile rows into the X buffer, pulses the buffer
// index reset after each tile and waits for the pad to drain before the next.
module redmule_x_loader
    import redmule_pkg::*;
#(
    parameter int DW      = DATA_W,
    parameter int BITW    = 16,
    parameter int W       = ARRAY_WIDTH,
    parameter int NTILE_W = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic [$clog2(W+1)-1:0]       cfg_rows_i,
    input  logic [NTILE_W-1:0]           cfg_tiles_i,
    input  logic [$clog2(DW/BITW+1)-1:0] cfg_last_elems_i,
    redmule_x_loader_if.slave            x_stream,
    output logic [DW-1:0]                x_data_o,
    output logic                         load_o,
    output logic                         rst_w_index_o,
    output logic                         pad_setup_o,
    input  logic                         full_i,
    input  logic                         empty_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [2:0]                   state_o
);
    localparam int RW = $clog2(W + 1);
    localparam int EW = $clog2(DW / BITW + 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOAD       = 3'd1;
    localparam logic [2:0] S_ACK        = 3'd2;
    localparam logic [2:0] S_WAIT_EMPTY = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    logic [2:0]         state;
    logic [RW-1:0]      row_cnt;
    logic [NTILE_W-1:0] tile_cnt;
    logic               first;
    logic [RW-1:0]      cfg_rows;
    logic [NTILE_W-1:0] cfg_tiles;
    logic [EW-1:0]      cfg_last_elems;
    logic               handshake;
    logic               last_tile;
    logic [EW-1:0]      mask_cnt;
    logic [DW-1:0]      masked;

    assign handshake = x_stream.valid & x_stream.ready;
    assign last_tile = (tile_cnt == cfg_tiles - NTILE_W'(1));
    assign mask_cnt  = last_tile ? cfg_last_elems : '0;

    redmule_x_lane_mask #(
        .DW   (DW),
        .BITW (BITW),
        .EW   (EW)
    ) u_lane_mask (
        .count       (mask_cnt),
        .raw_word    (x_stream.data),
        .masked_word (masked)
    );

    // Buffer controls and status decode straight from the state.
    always_comb begin
        x_stream.ready = (state == S_LOAD);
        load_o         = handshake;
        x_data_o       = (state == S_LOAD) ? masked : '0;
        rst_w_index_o  = (state == S_ACK);
        pad_setup_o    = (state == S_ACK) & first;
        done_o         = (state == S_DONE);
        busy_o         = (state != S_IDLE);
        state_o        = state;
    end

    // Tile sequencing FSM with row/tile counters; clear beats every other event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= S_IDLE;
            row_cnt        <= '0;
            tile_cnt       <= '0;
            first          <= 1'b0;
            err_o          <= 1'b0;
            cfg_rows       <= '0;
            cfg_tiles      <= '0;
            cfg_last_elems <= '0;
        end else if (clear_i) begin
            state          <= S_IDLE;
            row_cnt        <= '0;
            tile_cnt       <= '0;
            first          <= 1'b0;
            err_o          <= 1'b0;
            cfg_rows       <= '0;
            cfg_tiles      <= '0;
            cfg_last_elems <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        cfg_rows       <= cfg_rows_i;
                        cfg_tiles      <= cfg_tiles_i;
                        cfg_last_elems <= cfg_last_elems_i;
                        row_cnt        <= '0;
                        tile_cnt       <= '0;
                        first          <= 1'b1;
                        state          <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (handshake) begin
                        if (row_cnt == cfg_rows - RW'(1)) begin
                            row_cnt <= '0;
                            state   <= S_ACK;
                        end else begin
                            row_cnt <= row_cnt + RW'(1);
                        end
                    end
                end
                S_ACK: begin
                    // A buffer that is not full here means rows went missing.
                    if (!full_i) begin
                        err_o <= 1'b1;
                    end
                    first    <= 1'b0;
                    tile_cnt <= tile_cnt + NTILE_W'(1);
                    if (tile_cnt + NTILE_W'(1) == cfg_tiles) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_WAIT_EMPTY;
                    end
                end
                S_WAIT_EMPTY: begin
                    if (empty_i) begin
                        state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
